out_port_arbiter: RTL and testbench



---
 rtl/out_port_arbiter.sv | 121 ++++++++++++
 tb/tb_out_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_arbiter.sv
// Packet-level round-robin arbiter for one router output port: locks the output
// to a single input from HEADER to TAIL and drives crossbar select and FIFO strobes.
module out_port_arbiter #(
    parameter int unsigned N_REQ     = 5,
    parameter int unsigned FLIT_ID_W = 3,
    parameter int unsigned SEL_W     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           valid,
    input  logic [N_REQ*FLIT_ID_W-1:0] flit_id,
    input  logic                       out_full,
    output logic [N_REQ-1:0]           grant,
    output logic [SEL_W-1:0]           sel,
    output logic [N_REQ-1:0]           rd_en,
    output logic                       wr_en,
    output logic                       busy
);

    localparam logic [FLIT_ID_W-1:0] TAIL  = FLIT_ID_W'(3'b100);
    localparam int unsigned          SUM_W = SEL_W + 1;
    localparam logic [SEL_W-1:0]     LAST  = SEL_W'(N_REQ - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [N_REQ-1:0]     grant_d;
    logic [SEL_W-1:0]     sel_d;
    logic [SEL_W-1:0]     ptr_q;
    logic [SEL_W-1:0]     ptr_d;
    logic                 busy_d;
    logic [N_REQ-1:0]     elig;
    logic [N_REQ-1:0]     rot;
    logic [SUM_W-1:0]     win;
    logic [FLIT_ID_W-1:0] owner_flit;
    logic                 xfer;

    // Rotate the eligible set so bit 0 is the input at ptr, pick the lowest set bit
    always_comb begin
        elig = req & valid;
        rot  = N_REQ'({elig, elig} >> ptr_q);
        win  = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                win = SUM_W'(ptr_q) + SUM_W'(j);
            end
        end
        if (win >= SUM_W'(N_REQ)) begin
            win = win - SUM_W'(N_REQ);
        end
    end

    // Flit type at the head of the owner's FIFO
    always_comb begin
        owner_flit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                owner_flit = owner_flit | flit_id[i*FLIT_ID_W +: FLIT_ID_W];
            end
        end
    end

    // Transfer strobes; reset suppresses them in the reset cycle itself
    always_comb begin
        xfer  = (state_q == LOCKED) && (|(grant & valid)) && !out_full && !rst;
        rd_en = xfer ? grant : '0;
        wr_en = xfer;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant;
        sel_d   = sel;
        ptr_d   = ptr_q;
        busy_d  = busy;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = LOCKED;
                    grant_d = N_REQ'(1) << win;
                    sel_d   = SEL_W'(win);
                    busy_d  = 1'b1;
                end
            end
            LOCKED: begin
                // Only a transferred TAIL ends the packet; a stray HEADER is just data
                if (xfer && (owner_flit == TAIL)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (sel == LAST) ? '0 : sel + SEL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant   <= '0;
            sel     <= '0;
            ptr_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            sel     <= sel_d;
            ptr_q   <= ptr_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: directed vector table, hand sequences for round robin
// and mid-packet reset, then random traffic against a packet-level reference model.
module tb_out_port_arbiter;

    localparam int unsigned N_REQ = 5;
    localparam int unsigned FW    = 3;
    localparam int unsigned SW    = 3;
    localparam logic [2:0]  HDR   = 3'b001;
    localparam logic [2:0]  PAY   = 3'b010;
    localparam logic [2:0]  TL    = 3'b100;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_REQ-1:0]      req = '0;
    logic [N_REQ-1:0]      valid = '0;
    logic [N_REQ*FW-1:0]   flit_id = '0;
    logic                  out_full = 1'b0;
    logic [N_REQ-1:0]      grant;
    logic [SW-1:0]         sel;
    logic [N_REQ-1:0]      rd_en;
    logic                  wr_en;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    out_port_arbiter #(.N_REQ(N_REQ), .FLIT_ID_W(FW), .SEL_W(SW)) dut (
        .clk(clk), .rst(rst), .req(req), .valid(valid), .flit_id(flit_id),
        .out_full(out_full), .grant(grant), .sel(sel), .rd_en(rd_en),
        .wr_en(wr_en), .busy(busy)
    );

    typedef struct {
        logic        r;
        logic [4:0]  rq;
        logic [4:0]  vl;
        logic [14:0] f;
        logic        full;
        logic [4:0]  g;
        logic [2:0]  s;
        logic        b;
        logic [4:0]  rd;
        logic        w;
    } vec_t;

    function automatic logic [14:0] fv(input int slot, input logic [2:0] code);
        logic [14:0] v;
        v = '0;
        v[slot*3 +: 3] = code;
        return v;
    endfunction

    function automatic vec_t mk(input logic [4:0] rq, input logic [4:0] vl,
                                input logic [14:0] f, input logic full,
                                input logic [4:0] g, input logic [2:0] s,
                                input logic b, input logic [4:0] rd, input logic w);
        vec_t v;
        v.r = 1'b0; v.rq = rq; v.vl = vl; v.f = f; v.full = full;
        v.g = g; v.s = s; v.b = b; v.rd = rd; v.w = w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then let combinational outputs settle
    task automatic drive(input logic r, input logic [4:0] rq, input logic [4:0] vl,
                         input logic [14:0] f, input logic full);
        @(negedge clk);
        rst = r; req = rq; valid = vl; flit_id = f; out_full = full;
        #2;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] g, input logic [2:0] s,
                           input logic b, input logic [4:0] rd, input logic w);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".sel"},   32'(sel),   32'(s));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".rd_en"}, 32'(rd_en), 32'(rd));
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(w));
    endtask

    vec_t tbl[$];

    // Reference model state (packet level: who owns the port, where priority starts)
    int          m_owner;
    int          m_ptr;
    int          m_sel;

    initial begin
        // Directed table: single requester, ptr advance, contention skip,
        // single-flit packet, backpressure, stray HEADER, bubble with req drop
        tbl.push_back(mk(5'b00010, 5'b00010, fv(1, HDR), 0, 5'b00000, 0, 0, 5'b00000, 0));
        tbl.push_back(mk(5'b00010, 5'b00010, fv(1, HDR), 0, 5'b00010, 1, 1, 5'b00010, 1));
        tbl.push_back(mk(5'b00010, 5'b00010, fv(1, PAY), 0, 5'b00010, 1, 1, 5'b00010, 1));
        tbl.push_back(mk(5'b00010, 5'b00010, fv(1, TL),  0, 5'b00010, 1, 1, 5'b00010, 1));
        tbl.push_back(mk(5'b00000, 5'b00000, '0,         0, 5'b00000, 1, 0, 5'b00000, 0));
        tbl.push_back(mk(5'b00110, 5'b00110, fv(1, HDR) | fv(2, HDR), 0, 5'b00000, 1, 0, 5'b00000, 0));
        tbl.push_back(mk(5'b00110, 5'b00110, fv(1, HDR) | fv(2, HDR), 0, 5'b00100, 2, 1, 5'b00100, 1));
        tbl.push_back(mk(5'b00110, 5'b00110, fv(1, HDR) | fv(2, TL),  0, 5'b00100, 2, 1, 5'b00100, 1));
        tbl.push_back(mk(5'b00101, 5'b00101, fv(0, TL)  | fv(2, HDR), 0, 5'b00000, 2, 0, 5'b00000, 0));
        tbl.push_back(mk(5'b00101, 5'b00101, fv(0, TL)  | fv(2, HDR), 0, 5'b00001, 0, 1, 5'b00001, 1));
        tbl.push_back(mk(5'b00101, 5'b00101, fv(0, HDR) | fv(2, TL),  0, 5'b00000, 0, 0, 5'b00000, 0));
        tbl.push_back(mk(5'b00101, 5'b00101, fv(0, HDR) | fv(2, TL),  0, 5'b00100, 2, 1, 5'b00100, 1));
        tbl.push_back(mk(5'b01000, 5'b01000, fv(3, HDR), 0, 5'b00000, 2, 0, 5'b00000, 0));
        tbl.push_back(mk(5'b01000, 5'b01000, fv(3, HDR), 0, 5'b01000, 3, 1, 5'b01000, 1));
        tbl.push_back(mk(5'b01001, 5'b01001, fv(3, PAY) | fv(0, HDR), 1, 5'b01000, 3, 1, 5'b00000, 0));
        tbl.push_back(mk(5'b01001, 5'b01001, fv(3, PAY) | fv(0, HDR), 1, 5'b01000, 3, 1, 5'b00000, 0));
        tbl.push_back(mk(5'b01001, 5'b01001, fv(3, PAY) | fv(0, HDR), 1, 5'b01000, 3, 1, 5'b00000, 0));
        tbl.push_back(mk(5'b01000, 5'b01000, fv(3, HDR), 0, 5'b01000, 3, 1, 5'b01000, 1));
        tbl.push_back(mk(5'b00000, 5'b00000, fv(3, TL),  0, 5'b01000, 3, 1, 5'b00000, 0));
        tbl.push_back(mk(5'b00000, 5'b00000, fv(3, TL),  0, 5'b01000, 3, 1, 5'b00000, 0));
        tbl.push_back(mk(5'b00000, 5'b01000, fv(3, TL),  0, 5'b01000, 3, 1, 5'b01000, 1));
        tbl.push_back(mk(5'b00000, 5'b00000, '0,         0, 5'b00000, 3, 0, 5'b00000, 0));

        drive(1'b1, '0, '0, '0, 1'b0);
        drive(1'b1, '0, '0, '0, 1'b0);
        foreach (tbl[k]) begin
            drive(tbl[k].r, tbl[k].rq, tbl[k].vl, tbl[k].f, tbl[k].full);
            chk_out($sformatf("vec%0d", k), tbl[k].g, tbl[k].s, tbl[k].b, tbl[k].rd, tbl[k].w);
        end

        // Round robin with all inputs requesting 2-flit packets: N,E,W,S,L,N
        drive(1'b1, '0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0);
        chk_out("reset", 5'b0, 3'd0, 1'b0, 5'b0, 1'b0);
        for (int p = 0; p < 6; p++) begin
            logic [14:0] all_hdr;
            logic [4:0]  oh;
            int          g;
            g = p % 5;
            oh = 5'(1 << g);
            all_hdr = fv(0, HDR) | fv(1, HDR) | fv(2, HDR) | fv(3, HDR) | fv(4, HDR);
            drive(1'b0, 5'b11111, 5'b11111, all_hdr, 1'b0);
            chk($sformatf("rr%0d.idle_grant", p), 32'(grant), 32'(0));
            drive(1'b0, 5'b11111, 5'b11111, all_hdr, 1'b0);
            chk_out($sformatf("rr%0d.hdr", p), oh, 3'(g), 1'b1, oh, 1'b1);
            all_hdr[g*3 +: 3] = TL;
            drive(1'b0, 5'b11111, 5'b11111, all_hdr, 1'b0);
            chk_out($sformatf("rr%0d.tail", p), oh, 3'(g), 1'b1, oh, 1'b1);
        end

        // Reset while L owns the port (ptr is 1 here), then N must win from ptr 0
        drive(1'b0, 5'b10000, 5'b10000, fv(4, HDR), 1'b0);
        chk("rst_seq.idle", 32'(grant), 32'(0));
        drive(1'b0, 5'b10000, 5'b10000, fv(4, HDR), 1'b0);
        chk_out("rst_seq.lock", 5'b10000, 3'd4, 1'b1, 5'b10000, 1'b1);
        drive(1'b1, 5'b10000, 5'b10000, fv(4, PAY), 1'b0);
        drive(1'b0, 5'b00000, 5'b00000, '0, 1'b0);
        chk_out("rst_seq.after", 5'b0, 3'd0, 1'b0, 5'b0, 1'b0);
        drive(1'b0, 5'b10001, 5'b10001, fv(0, HDR) | fv(4, HDR), 1'b0);
        chk("rst_seq.idle2", 32'(grant), 32'(0));
        drive(1'b0, 5'b10001, 5'b10001, fv(0, HDR) | fv(4, HDR), 1'b0);
        chk_out("rst_seq.n_wins", 5'b00001, 3'd0, 1'b1, 5'b00001, 1'b1);

        // Random traffic against the reference model
        drive(1'b1, '0, '0, '0, 1'b0);
        m_owner = -1; m_ptr = 0; m_sel = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        r;
            logic        full;
            logic [4:0]  rq;
            logic [4:0]  vl;
            logic [14:0] f;
            logic [4:0]  eg;
            logic [4:0]  erd;
            logic [2:0]  ofl;
            logic [4:0]  e;
            bit          xf;
            r    = ($urandom_range(0, 99) == 0);
            rq   = 5'($urandom);
            vl   = 5'($urandom) | 5'($urandom);
            full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 5; i++) begin
                case ($urandom_range(0, 2))
                    0:       f[i*3 +: 3] = HDR;
                    1:       f[i*3 +: 3] = PAY;
                    default: f[i*3 +: 3] = TL;
                endcase
            end
            drive(r, rq, vl, f, full);

            eg = '0; erd = '0; xf = 0; ofl = '0;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                ofl = f[m_owner*3 +: 3];
                xf = vl[m_owner] && !full && !r;
                if (xf) erd[m_owner] = 1'b1;
            end
            chk_out($sformatf("rnd%0d", c), eg, 3'(m_sel), (m_owner >= 0), erd, xf);

            if (r) begin
                m_owner = -1; m_ptr = 0; m_sel = 0;
            end else if (m_owner < 0) begin
                e = rq & vl;
                for (int k = 0; k < 5; k++) begin
                    int cand;
                    cand = (m_ptr + k) % 5;
                    if (m_owner < 0 && e[cand]) begin
                        m_owner = cand;
                        m_sel   = cand;
                    end
                end
            end else if (xf && ofl == TL) begin
                m_ptr   = (m_owner + 1) % 5;
                m_owner = -1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
